// File: rtl/ref_clock_pll_model_pkg.sv
// Shared types and default constants for the clock-sampled reference PLL model.
`timescale 1ns/1ps

package ref_clock_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lock_state_t;

  // Defaults assume a 500 MHz sampling clock against a 50 MHz reference.
  localparam int NOM_PERIOD   = 10;
  localparam int PERIOD_TOL   = 1;
  localparam int LOCK_PERIODS = 64;

endpackage

// File: rtl/ref_clock_pll_model_if.sv
// Reference-clock bundle between the board/test harness and the PLL model.
`timescale 1ns/1ps

interface ref_clock_pll_model_if;

  logic grs_n;
  logic clkin1;
  logic clkout1;
  logic pll_lock;

  modport master (
    output grs_n,
    output clkin1,
    input  clkout1,
    input  pll_lock
  );

  modport slave (
    input  grs_n,
    input  clkin1,
    output clkout1,
    output pll_lock
  );

endinterface

// File: rtl/ref_clock_pll_model_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
`timescale 1ns/1ps

module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ref_clock_pll_model.sv
// Behavioural reference-clock PLL: qualifies clkin1 periods, asserts pll_lock
// after a run of good periods and outputs clkin1/2 while locked.
`timescale 1ns/1ps

module ref_clock_pll_model #(
  parameter int CLKIN_FREQ_MHZ = 50,
  parameter int NOM_PERIOD     = ref_clock_pkg::NOM_PERIOD,
  parameter int PERIOD_TOL     = ref_clock_pkg::PERIOD_TOL,
  parameter int LOCK_PERIODS   = ref_clock_pkg::LOCK_PERIODS,
  parameter int CNT_W          = 8
) (
  input  logic                  clk_tb,
  input  logic                  rst_n,
  ref_clock_pll_model_if.slave  pll
);

  import ref_clock_pkg::*;

  localparam int GOOD_W = $clog2(LOCK_PERIODS + 1);

  localparam logic [CNT_W-1:0]  PER_LO   = CNT_W'(NOM_PERIOD - PERIOD_TOL);
  localparam logic [CNT_W-1:0]  PER_HI   = CNT_W'(NOM_PERIOD + PERIOD_TOL);
  localparam logic [CNT_W-1:0]  PER_TO   = CNT_W'(2 * NOM_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_PERIODS);

  if (CLKIN_FREQ_MHZ <= 0 || NOM_PERIOD <= PERIOD_TOL) begin : g_param_check
    $error("ref_clock_pll_model: illegal period parameters");
  end

  logic              rst_i_n;
  logic              rst_sync_n;
  logic              clkin_s2;
  logic              clkin_s3;
  logic              edge_det;
  logic              judge;
  logic              in_tol;
  logic              timeout;
  logic              fail;
  logic              armed;
  logic [CNT_W-1:0]  per_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_next;
  lock_state_t       state;
  logic              lock_q;
  logic              clkout_q;

  assign rst_i_n = rst_n & pll.grs_n;

  // Reset asserts asynchronously but releases on clk_tb.
  sync2 u_rst_sync (
    .clk   (clk_tb),
    .rst_n (rst_i_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync2 u_clkin_sync (
    .clk   (clk_tb),
    .rst_n (rst_sync_n),
    .d     (pll.clkin1),
    .q     (clkin_s2)
  );

  always_ff @(posedge clk_tb or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      clkin_s3 <= 1'b0;
    end else begin
      clkin_s3 <= clkin_s2;
    end
  end

  // An edge coinciding with the timeout count wins: timeout needs no edge.
  always_comb begin
    edge_det  = clkin_s2 & ~clkin_s3;
    judge     = edge_det & armed;
    in_tol    = (per_cnt >= PER_LO) && (per_cnt <= PER_HI);
    timeout   = ~edge_det & (per_cnt == PER_TO);
    fail      = (judge & ~in_tol) | timeout;
    good_next = good_cnt;
    if (fail) begin
      good_next = '0;
    end else if (judge && (good_cnt != GOOD_MAX)) begin
      good_next = good_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_tb or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      per_cnt  <= '0;
      armed    <= 1'b0;
      good_cnt <= '0;
    end else begin
      good_cnt <= good_next;
      if (edge_det) begin
        per_cnt <= CNT_W'(1);
        armed   <= 1'b1;
      end else if (per_cnt != {CNT_W{1'b1}}) begin
        per_cnt <= per_cnt + 1'b1;
      end
    end
  end

  // The divider flop is held at 0 outside LOCKED so the first locked edge
  // always produces a rising clkout1.
  always_ff @(posedge clk_tb or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= ACQUIRE;
      lock_q   <= 1'b0;
      clkout_q <= 1'b0;
    end else begin
      case (state)
        ACQUIRE: begin
          clkout_q <= 1'b0;
          if (good_next == GOOD_MAX) begin
            state  <= LOCKED;
            lock_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (fail) begin
            state    <= ACQUIRE;
            lock_q   <= 1'b0;
            clkout_q <= 1'b0;
          end else if (edge_det) begin
            clkout_q <= ~clkout_q;
          end
        end
        default: begin
          state    <= ACQUIRE;
          lock_q   <= 1'b0;
          clkout_q <= 1'b0;
        end
      endcase
    end
  end

  assign pll.clkout1  = clkout_q;
  assign pll.pll_lock = lock_q;

endmodule

// File: tb/tb_ref_clock_pll_model.sv
// Directed bench for ref_clock_pll_model: period-qualification table plus
// stopped-clock, single-bad-period and global-reset sequences.
`timescale 1ns/1ps

module tb_ref_clock_pll_model;

  typedef struct {
    string   name;
    realtime per_ns;
    int      n_per;
    int      exp_lock;
    int      exp_rises;
    int      exp_toggles;
    int      exp_clk;
    int      exp_high;
  } vec_t;

  logic clk_tb = 1'b0;
  logic rst_n;

  int tests = 0;
  int fails = 0;

  int   lock_rises  = 0;
  int   lock_falls  = 0;
  int   clk_toggles = 0;
  int   high_run    = 0;
  int   last_high   = 0;
  logic prev_lock   = 1'b0;
  logic prev_clk    = 1'b0;

  vec_t vecs[8];

  ref_clock_pll_model_if pif ();

  ref_clock_pll_model dut (
    .clk_tb (clk_tb),
    .rst_n  (rst_n),
    .pll    (pif.slave)
  );

  always #1 clk_tb = ~clk_tb;

  // Edge counters sampled mid-cycle; the bench compares deltas against them.
  always @(negedge clk_tb) begin
    if (pif.pll_lock === 1'b1 && prev_lock === 1'b0) lock_rises <= lock_rises + 1;
    if (pif.pll_lock === 1'b0 && prev_lock === 1'b1) lock_falls <= lock_falls + 1;
    if (pif.clkout1 !== prev_clk) clk_toggles <= clk_toggles + 1;
    if (pif.clkout1 === 1'b1) begin
      high_run <= high_run + 1;
    end else begin
      if (high_run != 0) last_high <= high_run;
      high_run <= 0;
    end
    prev_lock <= pif.pll_lock;
    prev_clk  <= pif.clkout1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_periods(input int n, input realtime per);
    for (int i = 0; i < n; i++) begin
      pif.clkin1 = 1'b1;
      #(per / 2.0);
      pif.clkin1 = 1'b0;
      #(per / 2.0);
    end
  endtask

  task automatic do_reset(input string name);
    rst_n      = 1'b0;
    pif.grs_n  = 1'b1;
    pif.clkin1 = 1'b0;
    #10;
    check_output({name, "_rst_lock"}, pif.pll_lock, 0);
    check_output({name, "_rst_clk"}, pif.clkout1, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk_tb);
    #0.5;
  endtask

  task automatic apply_stimulus(input vec_t v);
    int br, bf, bt;
    do_reset(v.name);
    br = lock_rises;
    bf = lock_falls;
    bt = clk_toggles;
    run_periods(v.n_per, v.per_ns);
    check_output({v.name, "_lock"}, pif.pll_lock, v.exp_lock);
    check_output({v.name, "_rises"}, lock_rises - br, v.exp_rises);
    check_output({v.name, "_falls"}, lock_falls - bf, 0);
    check_output({v.name, "_toggles"}, clk_toggles - bt, v.exp_toggles);
    check_output({v.name, "_clk"}, pif.clkout1, v.exp_clk);
    if (v.exp_high != 0) check_output({v.name, "_high_run"}, last_high, v.exp_high);
  endtask

  initial begin
    int bf;
    vecs[0] = '{"nom_100",   20.0, 100, 1, 1, 35, 1, 10};
    vecs[1] = '{"nom_65",    20.0,  65, 1, 1,  0, 0,  0};
    vecs[2] = '{"nom_64",    20.0,  64, 0, 0,  0, 0,  0};
    vecs[3] = '{"slow_tol",  22.0, 100, 1, 1, 35, 1, 11};
    vecs[4] = '{"fast_tol",  18.0, 100, 1, 1, 35, 1,  9};
    vecs[5] = '{"slow_out",  24.0, 100, 0, 0,  0, 0,  0};
    vecs[6] = '{"fast_out",  16.0, 100, 0, 0,  0, 0,  0};
    vecs[7] = '{"f40mhz",    25.0, 100, 0, 0,  0, 0,  0};

    rst_n      = 1'b0;
    pif.grs_n  = 1'b1;
    pif.clkin1 = 1'b0;

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    // Stopped clock after lock, then restart.
    do_reset("stop");
    run_periods(100, 20.0);
    check_output("stop_locked", pif.pll_lock, 1);
    bf = lock_falls;
    #20;
    check_output("stop_still_locked", pif.pll_lock, 1);
    #22;
    check_output("stop_lost", pif.pll_lock, 0);
    check_output("stop_clk", pif.clkout1, 0);
    check_output("stop_falls", lock_falls - bf, 1);
    #58;
    run_periods(64, 20.0);
    check_output("restart_64", pif.pll_lock, 0);
    run_periods(1, 20.0);
    check_output("restart_65", pif.pll_lock, 1);

    // One 30 ns period while locked.
    pif.clkin1 = 1'b1;
    #10;
    pif.clkin1 = 1'b0;
    #20;
    run_periods(1, 20.0);
    check_output("bad_lost", pif.pll_lock, 0);
    check_output("bad_clk", pif.clkout1, 0);
    run_periods(63, 20.0);
    check_output("bad_63", pif.pll_lock, 0);
    run_periods(1, 20.0);
    check_output("bad_relock", pif.pll_lock, 1);

    // Global reset pulse while locked with clkout1 high.
    do_reset("grs");
    run_periods(66, 20.0);
    check_output("grs_pre_lock", pif.pll_lock, 1);
    check_output("grs_pre_clk", pif.clkout1, 1);
    pif.grs_n = 1'b0;
    #0.3;
    check_output("grs_lock", pif.pll_lock, 0);
    check_output("grs_clk", pif.clkout1, 0);
    #9.7;
    pif.grs_n = 1'b1;
    #20;
    run_periods(64, 20.0);
    check_output("grs_64", pif.pll_lock, 0);
    run_periods(1, 20.0);
    check_output("grs_relock", pif.pll_lock, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ref_clock_pll_model.md
# ref_clock_pll_model

Behavioural, clock-sampled model of the Ethernet reference-clock PLL (`ref_clock` role) plus its global-reset hook (`GTP_GRS` role) for simulation of the Ethernet test design. It samples the 50 MHz board clock `clkin1` with the fast clock `clk_tb`, qualifies its period, and produces a divided reference clock `clkout1` together with a lock indicator `pll_lock`. Downstream logic holds off on `pll_lock`, which must rise once and stay high while `clkin1` is healthy.

## Interface
- `CLKIN_FREQ_MHZ`, default 50: nominal `clkin1` frequency, documentation only.
- `NOM_PERIOD`, default 10: nominal `clkin1` period in `clk_tb` cycles (20 ns / 2 ns).
- `PERIOD_TOL`, default 1: accepted deviation from `NOM_PERIOD`, in cycles.
- `LOCK_PERIODS`, default 64: consecutive good periods needed before lock.
- `CNT_W`, default 8: period-counter width.

Ports:
- `clk_tb`  in  1  sampling clock, 500 MHz.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `grs_n`  in  1  global reset, active-low; ANDed with `rst_n`. Tie to 1 when unused.
- `clkin1`  in  1  reference input, asynchronous to `clk_tb`.
- `clkout1`  out  1  `clkin1`/2 (25 MHz), 50 % duty, `clk_tb`-registered.
- `pll_lock`  out  1  high while the input is qualified.

## Operation
- Internal reset: `rst_i_n = rst_n & grs_n`. Asynchronous assert, synchronous deassert through a 2-flop synchroniser.
- `clkin1` passes through a 2-flop synchroniser, then a third flop feeds the edge detect. A rising edge is `s2 & ~s3`.
- Period counter (`CNT_W` bits, saturating):
  - Clears to 1 on each rising edge.
  - Otherwise increments each cycle.
- On each rising edge the value before the clear is the measured period.
  - Good period: `|period − NOM_PERIOD| ≤ PERIOD_TOL`.
  - The first edge after reset only starts measurement and is not judged.
- Good-period counter:
  - Increments on a good period, saturating at `LOCK_PERIODS`.
  - A bad period clears it to 0.
  - Timeout also clears it to 0. Timeout occurs when the period counter reaches `2*NOM_PERIOD` with no edge (stopped clock).
- FSM states:
  - ACQUIRE → LOCKED when the good count reaches `LOCK_PERIODS`.
  - LOCKED → ACQUIRE on a bad period or timeout.
  - Reset enters ACQUIRE.
- `pll_lock` is 1 exactly in LOCKED (registered).
- `clkout1`:
  - In LOCKED it toggles on every detected rising edge of `clkin1`.
  - In ACQUIRE it is forced to 0, and the toggle flop is cleared so the first LOCKED edge drives it to 1.
- Simultaneous edge and timeout in the same cycle: the edge wins and the period is judged normally.

## Timing
- Reset values: `clkout1` = 0, `pll_lock` = 0, all counters 0, state ACQUIRE.
- `clkin1` edge to detected edge: 3 `clk_tb` cycles. Detected edge to `clkout1` change: 1 cycle.
- Lock latency from the first `clkin1` edge after reset: (`LOCK_PERIODS`+1) input periods + 4 cycles, about 1.31 µs at defaults.
- Loss of lock: `pll_lock` falls 1 cycle after the failing edge, or after the timeout cycle.
- Reset mid-operation: outputs drop to 0 immediately (asynchronously); re-acquisition starts from scratch.
- No glitches: both outputs come straight from flops.

## Structure
- Shared package `ref_clock_pkg` holds:
  - the state enum (ACQUIRE, LOCKED);
  - the default constants `NOM_PERIOD`, `PERIOD_TOL`, `LOCK_PERIODS`.
- One sub-module, `sync2` (a 2-flop synchroniser), used twice: once for the reset release and once for `clkin1`.
- Everything else lives in the top: period counter, qualifier, lock FSM and divider.

## Test plan
- Steady input: `clk_tb` 500 MHz, `clkin1` 50 MHz, reset released at 20 ns.
  - `pll_lock` rises exactly once, at about 1.31 µs.
  - `pll_lock` stays high to the 4 ms end of run.
  - `clkout1` period is 40 ns, 20 ns high.
- Lock stability check: sample `pll_lock` every `clk_tb` cycle and count rising edges.
  - The count must be exactly 1.
  - Any low sample after the first rise is an error.
  - Log `err_chk` = 0 throughout.
- Frequency error: `clkin1` at 40 MHz (period 12.5 cycles) → `pll_lock` never asserts and `clkout1` stays 0.
- Stopped clock: hold `clkin1` low for 100 ns after lock.
  - `pll_lock` falls within 21 cycles.
  - On restart it re-locks after 65 periods.
- Single bad period: one 30 ns `clkin1` period after lock → `pll_lock` drops for at least 64 periods, then returns.
- `grs_n` pulsed low for 10 ns while locked → both outputs go to 0 immediately; lock re-acquired about 1.31 µs after release.
